apb_cmd_master: RTL and testbench

APB requester that turns a simple valid/ready command stream into APB3 transfers toward the timer's register slave (`timer_top`). It buffers commands in a small FIFO, runs the IDLE/SETUP/ACCESS sequence, tolerates `pready` wait states with a timeout, and returns one response per command. It sits between a controller or sequencer and the timer's APB port, at the initiator end of the bus the timer responds on.

---
 rtl/apb_cmd_master.sv | 187 ++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 requester: buffers valid/ready commands in a small FIFO and plays each one out as an
// IDLE -> SETUP -> ACCESS transfer. Wait states are bounded by a timeout, and every accepted
// command gets exactly one response pulse, in command order.
module apb_cmd_master #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // APB requester side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned EntryW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              done, abort;

  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  logic              rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

  // Command storage; entries need no reset since count_q gates their use.
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transfer sequencing, wait counting and APB strobes.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wait_d  = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        psel    = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + WaitW'(1);
          // This cycle is the TIMEOUT-th stalled one: give up at its closing edge.
          if (wait_q == WaitW'(TIMEOUT - 1)) begin
            abort   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Address/control/data load on pop and hold until the next pop.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (pop) begin
      pwrite_q <= head_write;
      paddr_q  <= head_addr;
      pwdata_q <= head_wdata;
    end
  end

  // One-cycle response; type/data/error fields are zero outside the pulse.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= done || abort;
      rsp_write_q <= (done || abort) && pwrite_q;
      rsp_err_q   <= abort;
      rsp_rdata_q <= (done && !pwrite_q) ? prdata : '0;
    end
  end

  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: an APB slave model with programmable wait states, a response
// scoreboard driven by an order-based memory model, a directed table and random traffic.
module tb_apb_cmd_master;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_write, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial forever #5 pclk = ~pclk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_pen;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int rsp_seen = 0;
  int wait_mode = 0;   // 0: no wait states, 1: random 0..20
  int fixed_wait = 0;  // one-shot wait count for the next transfer
  int fixed_req = 0;
  int fixed_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 7 + 3);
  endfunction

  // APB slave: decides pready just after each edge, commits writes on the completing cycle.
  initial begin : slave
    logic [DW-1:0] mem [256];
    int  remaining;
    bit  in_acc;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    pready = 1'b0;
    prdata = '0;
    remaining = 0;
    in_acc = 0;
    forever begin
      @(posedge pclk);
      #1;
      if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1;
          if (fixed_req != fixed_ack) begin
            remaining = fixed_wait;
            fixed_ack = fixed_req;
          end else if (wait_mode == 1) begin
            remaining = $urandom_range(0, 20);
          end else begin
            remaining = 0;
          end
        end else if (remaining > 0) begin
          remaining--;
        end
        pready = (remaining == 0);
        prdata = mem[paddr];
        if (pready && pwrite) mem[paddr] = pwdata;
      end else begin
        in_acc = 0;
        pready = 1'b0;
        prdata = DW'($urandom);
      end
    end
  end

  // Scoreboard: commands in acceptance order; an ACCESS stalled TMO cycles is an error.
  initial begin : monitor
    cmd_t          q[$];
    cmd_t          h;
    logic [DW-1:0] ref_mem [256];
    int            stall;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    stall = 0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        q.delete();
        stall = 0;
      end else begin
        if (rsp_valid) begin
          if (q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            h = q.pop_front();
            exp_err = (stall >= TMO);
            exp_rd  = (exp_err || h.write) ? '0 : ref_mem[h.addr];
            if (h.write && !exp_err) ref_mem[h.addr] = h.wdata;
            check("sb_rsp_write", 32'(rsp_write), 32'(h.write));
            check("sb_rsp_err", 32'(rsp_err), 32'(exp_err));
            check("sb_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
            stall = 0;
            rsp_seen++;
          end
          check("sb_idle_after_rsp", 32'({psel, penable}), 32'd0);
        end
        if (penable) check("sb_penable_psel", 32'(psel), 32'd1);
        if (psel) begin
          if (q.size() == 0) begin
            check("sb_psel_no_cmd", 32'(psel), 32'd0);
          end else begin
            check("sb_paddr", 32'(paddr), 32'(q[0].addr));
            check("sb_pwrite", 32'(pwrite), 32'(q[0].write));
            if (q[0].write) check("sb_pwdata", 32'(pwdata), 32'(q[0].wdata));
          end
          if (penable && !pready) stall++;
        end
        if (cmd_valid && cmd_ready) q.push_back('{cmd_write, cmd_addr, cmd_wdata});
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Offer one command; returns #1 after the accepting edge with the stall count.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int stalled);
    stalled = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && stalled < 300) begin
      tick();
      stalled++;
    end
    if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output bit got, output int pen);
    int n;
    got = 0;
    pen = 0;
    n = 0;
    while (!got && n < limit) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (penable) pen++;
        tick();
        n++;
      end
    end
  endtask

  initial begin : main
    vec_t tbl [9];
    bit   got;
    int   pen, st, base;

    tbl[0] = '{1'b1, 8'h01, 8'h80, 0,  1'b0, 8'h00, 1};
    tbl[1] = '{1'b0, 8'h01, 8'h00, 0,  1'b0, 8'h80, 1};
    tbl[2] = '{1'b1, 8'h10, 8'h5A, 2,  1'b0, 8'h00, 3};
    tbl[3] = '{1'b0, 8'h10, 8'h00, 3,  1'b0, 8'h5A, 4};
    tbl[4] = '{1'b1, 8'h10, 8'hFF, 16, 1'b1, 8'h00, 16};
    tbl[5] = '{1'b0, 8'h10, 8'h00, 15, 1'b0, 8'h5A, 16};
    tbl[6] = '{1'b0, 8'h01, 8'h00, 16, 1'b1, 8'h00, 16};
    tbl[7] = '{1'b1, 8'h00, 8'h00, 0,  1'b0, 8'h00, 1};
    tbl[8] = '{1'b0, 8'h00, 8'h00, 1,  1'b0, 8'h00, 2};

    // Reset values
    tick();
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", 32'(pwdata), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_write, rsp_err}), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    presetn = 1'b1;
    tick();

    // Latency of a single write 0x80 -> 0x01 from empty/idle
    send(1'b1, 8'h01, 8'h80, st);
    check("lat_k_psel", 32'(psel), 32'd0);
    check("lat_k_busy", 32'(busy), 32'd1);
    tick();
    check("lat_setup", 32'({psel, penable}), 32'b10);
    check("lat_setup_ctl", 32'({pwrite, paddr, pwdata}), 32'h1_01_80);
    tick();
    check("lat_access", 32'({psel, penable}), 32'b11);
    check("lat_access_ctl", 32'({pwrite, paddr, pwdata}), 32'h1_01_80);
    tick();
    check("lat_rsp", 32'({rsp_valid, rsp_write, rsp_err}), 32'b110);
    check("lat_rsp_apb", 32'({psel, penable}), 32'd0);
    check("lat_rsp_busy", 32'(busy), 32'd0);
    tick();
    check("lat_rsp_pulse", 32'(rsp_valid), 32'd0);

    // Directed table: wait-state counts around the timeout boundary
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].waits > 0) begin
        fixed_wait = tbl[i].waits;
        fixed_req++;
      end
      send(tbl[i].write, tbl[i].addr, tbl[i].wdata, st);
      wait_rsp(60, got, pen);
      check($sformatf("tbl%0d_got", i), 32'(got), 32'd1);
      check($sformatf("tbl%0d_pen", i), 32'(pen), 32'(tbl[i].exp_pen));
      check($sformatf("tbl%0d_err", i), 32'(rsp_err), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_write", i), 32'(rsp_write), 32'(tbl[i].write));
      check($sformatf("tbl%0d_rdata", i), 32'(rsp_rdata), 32'(tbl[i].exp_rdata));
      tick();
    end

    // Timeout followed by a queued command that completes normally
    fixed_wait = 1000;
    fixed_req++;
    send(1'b0, 8'h05, 8'h00, st);
    send(1'b1, 8'h05, 8'hC3, st);
    wait_rsp(60, got, pen);
    check("tmo_pen", 32'(pen), 32'd16);
    check("tmo_rsp", 32'({got, rsp_err, rsp_write}), 32'b110);
    check("tmo_rdata", 32'(rsp_rdata), 32'd0);
    tick();
    wait_rsp(60, got, pen);
    check("tmo_next", 32'({got, rsp_err, rsp_write}), 32'b101);
    tick();

    // Five pushes while a stalled transfer is in flight
    fixed_wait = 8;
    fixed_req++;
    base = rsp_seen;
    send(1'b1, 8'h30, 8'h01, st);
    for (int i = 0; i < 4; i++) begin
      send(i[0], 8'(8'h31 + i), 8'(8'h11 * (i + 2)), st);
      check($sformatf("fill%0d_nostall", i), 32'(st), 32'd0);
    end
    check("fill_ready_drop", 32'(cmd_ready), 32'd0);
    send(1'b0, 8'h30, 8'h00, st);
    check("fill_5th_stalled", 32'(st > 0), 32'd1);
    for (int n = 0; n < 300 && rsp_seen < base + 6; n++) tick();
    check("fill_rsp_count", 32'(rsp_seen - base), 32'd6);
    tick();
    check("fill_busy_end", 32'(busy), 32'd0);

    // Reset during ACCESS with two commands queued
    fixed_wait = 1000;
    fixed_req++;
    for (int i = 0; i < 3; i++) send(1'b0, 8'(i), 8'h00, st);
    for (int n = 0; n < 20 && !penable; n++) tick();
    check("rstmid_in_access", 32'(penable), 32'd1);
    tick();
    tick();
    base = rsp_seen;
    #2;
    presetn = 1'b0;
    #1;
    check("rstmid_apb", 32'({psel, penable}), 32'd0);
    check("rstmid_rsp", 32'(rsp_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    presetn = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("rstmid_quiet", 32'({psel, busy, rsp_valid}), 32'd0);
    end
    check("rstmid_no_rsp", 32'(rsp_seen - base), 32'd0);
    check("rstmid_ready_after", 32'(cmd_ready), 32'd1);

    // Random traffic with random wait states (some beyond the timeout)
    wait_mode = 1;
    base = rsp_seen;
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), st);
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int n = 0; n < 3000 && rsp_seen < base + 40; n++) tick();
    check("rand_rsp_count", 32'(rsp_seen - base), 32'd40);
    tick();
    check("rand_busy_end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
